// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation scheduler: the controller state
// encoding and the default values of the scheduler parameters.
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENCHENDO = 3'd1,
        REGANDO  = 3'd2,
        LIMPEZA  = 3'd3,
        ERRO     = 3'd4
    } state_t;

    localparam int N_SETORES_DEF      = 4;
    localparam int T_REGA_DEF         = 100;
    localparam int T_LIMPEZA_DEF      = 20;
    localparam int LIMPEZA_CICLOS_DEF = 3;
    localparam int TW_DEF             = 8;

endpackage

// File: rtl/irrigation_scheduler_rr_arbiter.sv
// Combinational N-way round-robin pick.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the highest-priority position this round
//   grant out N   one-hot winner (all-zero when no request)
//   idx   out IW  index of the winner
//   valid out 1   at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Position reached by stepping 'off' places forward from p, wrapping at N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value held and no latch is inferred.
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan from the farthest offset to the nearest: the requester closest
        // to ptr is assigned last and therefore wins.
        for (int off = N - 1; off >= 0; off--) begin
            if (req[wrap_add(ptr, off)]) begin
                grant                     = '0;
                grant[wrap_add(ptr, off)] = 1'b1;
                idx                       = wrap_add(ptr, off);
                valid                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Time-shares the tank/pump irrigation machine between N_SETORES sectors.
// One sector at a time is granted a fixed watering slot, round-robin, in
// sprinkler or drip mode; watering is gated on tank level, a cleaning pass
// follows every LIMPEZA_CICLOS completed slots, and fault input E parks the
// controller in ERRO. All outputs are registered.
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous active-low reset
//   Req[N]         in   per-sector watering request (level)
//   Modo[N]        in   per-sector mode, 1 = aspersao, 0 = gotejamento
//   H, M, L        in   tank level full / at-or-above medium / at-or-above low
//   E              in   fault input (level)
//   Grant[N]       out  one-hot sector grant
//   S_Enchendo     out  fill valve command
//   S_Aspersao     out  sprinkler pump command
//   S_Gotejamento  out  drip valve command
//   S_Limpeza      out  cleaning command
//   S_Erro         out  error indicator
//   Ocupado        out  high whenever the controller is not idle
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_SETORES      = N_SETORES_DEF,
    parameter int T_REGA         = T_REGA_DEF,
    parameter int T_LIMPEZA      = T_LIMPEZA_DEF,
    parameter int LIMPEZA_CICLOS = LIMPEZA_CICLOS_DEF,
    parameter int TW             = TW_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N_SETORES-1:0] Req,
    input  logic [N_SETORES-1:0] Modo,
    input  logic                 H,
    input  logic                 M,
    input  logic                 L,
    input  logic                 E,
    output logic [N_SETORES-1:0] Grant,
    output logic                 S_Enchendo,
    output logic                 S_Aspersao,
    output logic                 S_Gotejamento,
    output logic                 S_Limpeza,
    output logic                 S_Erro,
    output logic                 Ocupado
);

    localparam int IW = $clog2(N_SETORES);
    localparam int CW = $clog2(LIMPEZA_CICLOS + 1);

    state_t               state, state_d;
    logic [TW-1:0]        timer, timer_d;
    logic [CW-1:0]        slots, slots_d;
    logic [IW-1:0]        ptr, ptr_d;
    logic [IW-1:0]        win, win_d;
    logic [N_SETORES-1:0] win_oh, win_oh_d;
    logic                 mode, mode_d;

    logic [N_SETORES-1:0] grant_d;
    logic                 enchendo_d, aspersao_d, gotejamento_d;
    logic                 limpeza_d, erro_d, ocupado_d;

    logic [N_SETORES-1:0] arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;

    rr_arbiter #(
        .N  (N_SETORES),
        .IW (IW)
    ) u_arb (
        .req   (Req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Next state, bookkeeping and next-output decode.
    always_comb begin
        state_d       = state;
        timer_d       = timer;
        slots_d       = slots;
        ptr_d         = ptr;
        win_d         = win;
        win_oh_d      = win_oh;
        mode_d        = mode;
        grant_d       = '0;
        enchendo_d    = 1'b0;
        aspersao_d    = 1'b0;
        gotejamento_d = 1'b0;
        limpeza_d     = 1'b0;
        erro_d        = 1'b0;

        if (E) begin
            state_d = ERRO;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!M) begin
                        state_d = ENCHENDO;
                    end else if (arb_valid) begin
                        state_d  = REGANDO;
                        win_d    = arb_idx;
                        win_oh_d = arb_grant;
                        mode_d   = Modo[arb_idx];
                        timer_d  = TW'(T_REGA - 1);
                    end
                end
                ENCHENDO: begin
                    if (H) state_d = IDLE;
                end
                REGANDO: begin
                    if (timer != '0) timer_d = timer - TW'(1);
                    if (!L) begin
                        // Tank ran dry: abandon the slot uncounted and keep the
                        // pointer so this sector is served first after refilling.
                        state_d = ENCHENDO;
                    end else if (timer == '0 || (Req & win_oh) == '0) begin
                        ptr_d = (win == IW'(N_SETORES - 1)) ? '0 : win + IW'(1);
                        if (slots == CW'(LIMPEZA_CICLOS - 1)) begin
                            slots_d = '0;
                            state_d = LIMPEZA;
                            timer_d = TW'(T_LIMPEZA - 1);
                        end else begin
                            slots_d = slots + CW'(1);
                            state_d = IDLE;
                        end
                    end
                end
                LIMPEZA: begin
                    if (timer == '0) state_d = IDLE;
                    else             timer_d = timer - TW'(1);
                end
                ERRO: begin
                    // E is already low on this path.
                    state_d = IDLE;
                    timer_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the state being entered so they change on the same
        // edge as the state register.
        unique case (state_d)
            ENCHENDO: enchendo_d = 1'b1;
            REGANDO: begin
                grant_d       = win_oh_d;
                aspersao_d    = mode_d;
                gotejamento_d = !mode_d;
            end
            LIMPEZA: limpeza_d = 1'b1;
            ERRO:    erro_d    = 1'b1;
            default: ;
        endcase
        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            timer         <= '0;
            slots         <= '0;
            ptr           <= '0;
            win           <= '0;
            win_oh        <= '0;
            mode          <= 1'b0;
            Grant         <= '0;
            S_Enchendo    <= 1'b0;
            S_Aspersao    <= 1'b0;
            S_Gotejamento <= 1'b0;
            S_Limpeza     <= 1'b0;
            S_Erro        <= 1'b0;
            Ocupado       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state         <= state_d;
            timer         <= timer_d;
            slots         <= slots_d;
            ptr           <= ptr_d;
            win           <= win_d;
            win_oh        <= win_oh_d;
            mode          <= mode_d;
            Grant         <= grant_d;
            S_Enchendo    <= enchendo_d;
            S_Aspersao    <= aspersao_d;
            S_Gotejamento <= gotejamento_d;
            S_Limpeza     <= limpeza_d;
            S_Erro        <= erro_d;
            Ocupado       <= ocupado_d;
        end
    end

endmodule
